// File: rtl/mem_io_responder.sv
// Memory/IO responder for the LC-3 MAR/MDR/MIO_EN interface: word RAM plus one
// memory-mapped I/O word, with a programmable number of wait states before R.
module mem_io_responder #(
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic        MIO_EN,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic [15:0] HEX_Data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] hex_q, hex_d;

  logic [15:0] mem [DEPTH];

  logic access;
  logic is_io;
  logic in_ram;
  logic mem_we;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (MIO_EN) state_d = S_WAIT;
      S_WAIT:    if (cnt_q == 4'd0) state_d = S_RESPOND;
      S_RESPOND: state_d = MIO_EN ? S_HOLD : S_IDLE;
      S_HOLD:    if (!MIO_EN) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: R comes straight from the registered state
  always_comb begin
    R = (state_q == S_RESPOND);
  end

  // Request latch, wait counter and access decode
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    hex_d   = hex_q;

    access = (state_q == S_WAIT) && (cnt_q == 4'd0);
    is_io  = (addr_q == IO_ADDR);
    in_ram = ((addr_q >> ADDR_BITS) == 16'd0);
    mem_we = access && we_q && in_ram && !is_io;

    if (state_q == S_IDLE && MIO_EN) begin
      addr_d  = ADDR;
      we_d    = WE;
      wdata_d = Data_from_CPU;
      cnt_d   = 4'(WAIT_CYCLES);
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    // Out-of-range addresses read as zero and drop writes instead of aliasing
    if (access) begin
      if (we_q) begin
        if (is_io) hex_d = wdata_q;
      end else if (is_io) begin
        dout_d = Switches;
      end else if (in_ram) begin
        dout_d = mem[addr_q[ADDR_BITS-1:0]];
      end else begin
        dout_d = 16'h0000;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      cnt_q  <= 4'd0;
      dout_q <= 16'h0000;
      hex_q  <= 16'h0000;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      hex_q  <= hex_d;
    end
  end

  always_ff @(posedge Clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  // Reset wins over a commit landing on the same edge
  always_ff @(posedge Clk) begin
    if (mem_we && !Reset_ah) begin
      mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
    end
  end

  assign Data_to_CPU = dout_q;
  assign HEX_Data    = hex_q;

endmodule
